// File: rtl/csi_rx_raw10_unpack_pkg.sv
// Shared types and constants for the CSI-2 RAW10 unpack path.
//   pix10_t         : one 10-bit pixel
//   pix4_t          : four pixels of one RAW10 group, [0] = earliest
//   grp_t           : five packed bytes of one RAW10 group, [0] = earliest
//   NUM_LANE_DEF    : default number of byte lanes per input beat
package csi_rx_raw10_unpack_pkg;
  localparam int NUM_LANE_DEF    = 2;
  localparam int RAW10_GRP_BYTES = 5;
  localparam int RAW10_GRP_PIX   = 4;

  typedef logic [9:0]                            pix10_t;
  typedef pix10_t [RAW10_GRP_PIX-1:0]            pix4_t;
  typedef logic [RAW10_GRP_BYTES-1:0][7:0]       grp_t;
endpackage

// File: rtl/csi_rx_raw10_unpack_grp.sv
// Purely combinational RAW10 group mapping: 5 bytes -> 4 x 10-bit pixels.
// Bytes 0..3 hold the 8 MSBs of pixels 0..3; byte 4 packs the 2 LSBs of
// each pixel, pixel 0 in bits [1:0].
//   grp : input  grp_t,  [0] = earliest byte
//   pix : output pix4_t, [0] = earliest pixel
module csi_rx_raw10_grp
  import csi_rx_raw10_unpack_pkg::*;
(
  input  grp_t  grp,
  output pix4_t pix
);
  always_comb begin
    pix = '0;
    for (int k = 0; k < RAW10_GRP_PIX; k++)
      pix[k] = {grp[k], grp[4][2*k +: 2]};
  end
endmodule

// File: rtl/csi_rx_raw10_unpack.sv
// RAW10 unpacker: regroups a NUM_LANE-byte-wide payload stream into 5-byte
// groups and emits 4 pixels per group, one cycle after the completing beat.
// Lines whose byte count is not a multiple of 5 are flagged at line end.
// Optional feature macro CSI_RAW10_LINE_CHK_EN: per-line pixel counter with
// line_len / sticky len_err reporting against H_PIXELS.
// Ports:
//   clock, reset (sync, active-high), enable (0 = hold in reset)
//   in_dat/in_vld/in_line/in_frame : payload bytes, lane 0 earliest
//   pix_dat/pix_vld                : 4 pixels + 1-cycle strobe
//   pix_line/pix_frame             : in_line/in_frame delayed 1 cycle
//   line_end/partial_err           : pulses on the cycle after in_line falls
//   line_len/len_err               : line length check (macro only, else 0)
module csi_rx_raw10_unpack
  import csi_rx_raw10_unpack_pkg::*;
#(
  parameter int NUM_LANE = csi_rx_raw10_unpack_pkg::NUM_LANE_DEF,
  parameter int H_PIXELS = 1920
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [NUM_LANE-1:0][7:0] in_dat,
  input  logic                     in_vld,
  input  logic                     in_line,
  input  logic                     in_frame,
  output pix4_t                    pix_dat,
  output logic                     pix_vld,
  output logic                     pix_line,
  output logic                     pix_frame,
  output logic                     line_end,
  output logic                     partial_err,
  output logic [15:0]              line_len,
  output logic                     len_err
);
  logic [3:0][7:0] acc_q, acc_d;
  logic [2:0]      fill_q, fill_d;
  logic            line_q, line_d, frame_q, frame_d;
  pix4_t           pix_dat_q, pix_dat_d;
  logic            pix_vld_q, pix_vld_d;
  logic            line_end_q, line_end_d, perr_q, perr_d;

  logic            rise, fall, ffall, take, clr;
  logic [2:0]      base;
  logic [3:0]      tot;
  logic [8:0][7:0] w;     // held bytes followed by this beat's bytes
  pix4_t           grp_pix;

  csi_rx_raw10_grp u_grp (.grp(w[4:0]), .pix(grp_pix));

  always_comb begin
    rise  = in_line & ~line_q;
    fall  = line_q & ~in_line;
    ffall = frame_q & ~in_frame;
    take  = in_vld & in_line;
    // A new line or a frame end discards stale bytes before this beat joins.
    clr   = rise | ffall;
    base  = clr ? 3'd0 : fill_q;
    tot   = {1'b0, base} + 4'(NUM_LANE);

    w = '0;
    for (int i = 0; i < 4; i++)
      if (i < int'(base)) w[i] = acc_q[i];
    for (int j = 0; j < NUM_LANE; j++)
      if (int'(base) + j < 9) w[int'(base) + j] = in_dat[j];

    acc_d      = acc_q;
    fill_d     = fill_q;
    pix_dat_d  = pix_dat_q;
    pix_vld_d  = 1'b0;
    line_end_d = 1'b0;
    perr_d     = 1'b0;
    line_d     = in_line;
    frame_d    = in_frame;

    if (take) begin
      if (tot >= 4'd5) begin
        pix_vld_d = 1'b1;
        pix_dat_d = grp_pix;
        for (int j = 0; j < 4; j++) acc_d[j] = w[j+5];
        fill_d = 3'(tot - 4'd5);
      end else begin
        for (int j = 0; j < 4; j++) acc_d[j] = w[j];
        fill_d = tot[2:0];
      end
    end else if (clr) begin
      fill_d = 3'd0;
    end

    // in_line is low here, so no beat was taken this cycle.
    if (fall) begin
      line_end_d = 1'b1;
      perr_d     = (fill_q != 3'd0);
      fill_d     = 3'd0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || !enable) begin
      acc_q      <= '0;
      fill_q     <= '0;
      line_q     <= 1'b0;
      frame_q    <= 1'b0;
      pix_dat_q  <= '0;
      pix_vld_q  <= 1'b0;
      line_end_q <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      fill_q     <= fill_d;
      line_q     <= line_d;
      frame_q    <= frame_d;
      pix_dat_q  <= pix_dat_d;
      pix_vld_q  <= pix_vld_d;
      line_end_q <= line_end_d;
      perr_q     <= perr_d;
    end
  end

  assign pix_dat     = pix_dat_q;
  assign pix_vld     = pix_vld_q;
  assign pix_line    = line_q;
  assign pix_frame   = frame_q;
  assign line_end    = line_end_q;
  assign partial_err = perr_q;

`ifdef CSI_RAW10_LINE_CHK_EN
  logic [15:0] cnt_q, cnt_d, len_q, len_d;
  logic        lerr_q, lerr_d;

  // Counting at emission time means the count is complete on the fall cycle.
  always_comb begin
    cnt_d  = cnt_q;
    len_d  = len_q;
    lerr_d = lerr_q;
    if (rise) cnt_d = '0;
    if (pix_vld_d) cnt_d = (cnt_d > 16'hFFFB) ? 16'hFFFF : cnt_d + 16'd4;
    if (fall) begin
      len_d  = cnt_q;
      lerr_d = lerr_q | (cnt_q != 16'(H_PIXELS));
    end
  end

  always_ff @(posedge clock) begin
    if (reset || !enable) begin
      cnt_q  <= '0;
      len_q  <= '0;
      lerr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      len_q  <= len_d;
      lerr_q <= lerr_d;
    end
  end

  assign line_len = len_q;
  assign len_err  = lerr_q;
`else
  logic unused_hpix;
  assign unused_hpix = ^16'(H_PIXELS);
  assign line_len    = '0;
  assign len_err     = 1'b0;
`endif
endmodule
